tl_sensor_cond: RTL and testbench

//  Vehicle-detector conditioner feeding the traffic light controller's Ta/Tb inputs.

---
 rtl/tl_sensor_cond.sv | 158 +++++++++++++++
 tb/tb_tl_sensor_cond.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_sensor_cond.sv
// Purpose : two-lane vehicle-detector conditioner (sync, debounce, hold-stretch) feeding Ta/Tb.
// Latency : Ta/Tb rise DEB_CYCLES+1 edges after raw first sampled high; fall HOLD_CYCLES+1 after low.
// Backpr. : none; detectors are level inputs and flags are continuously valid registered levels.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   raw_a, raw_b     asynchronous loop-detector lines (1 = vehicle present)
//   Ta, Tb           conditioned traffic flags (registered, Moore)
//   clr_cnt          synchronous clear of both vehicle counters   (TL_SENS_CNT_EN)
//   cnt_a, cnt_b     saturating qualified-vehicle counters        (TL_SENS_CNT_EN)
// Build option: define TL_SENS_CNT_EN to include the per-lane vehicle counters.
module tl_sensor_cond #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TL_SENS_CNT_EN
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
`endif
  input  logic             raw_a,
  input  logic             raw_b,
  output logic             Ta,
  output logic             Tb
);

  localparam int TMAX = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] DEB_LAST  = TW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RISE  = 2'd1,
    ST_OCC   = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Index 0 is lane A, index 1 is lane B throughout.
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  state_e        state_q [2];
  state_e        state_d [2];
  logic [TW-1:0] tmr_q   [2];
  logic [TW-1:0] tmr_d   [2];
  logic [1:0]    flag_q;
  logic [1:0]    flag_d;
  logic [1:0]    cnt_evt;

  // Two-flop synchroniser; the FSMs only ever see sync2_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {raw_b, raw_a};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_EMPTY;
        tmr_q[i]   <= '0;
      end
      flag_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
      flag_q <= flag_d;
    end
  end

  always_comb begin
    cnt_evt = 2'b00;
    flag_d  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      unique case (state_q[i])
        ST_EMPTY: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_RISE;
            tmr_d[i]   = TMR_ONE;
          end
        end
        ST_RISE: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_EMPTY;
            tmr_d[i]   = '0;
          end else if (tmr_q[i] == DEB_LAST) begin
            state_d[i] = ST_OCC;
            tmr_d[i]   = '0;
            cnt_evt[i] = 1'b1;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_ONE;
          end
        end
        ST_OCC: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_HOLD;
            tmr_d[i]   = TMR_ONE;
          end
        end
        ST_HOLD: begin
          // A return to high while holding is treated as the same vehicle.
          if (sync2_q[i]) begin
            state_d[i] = ST_OCC;
            tmr_d[i]   = '0;
          end else if (tmr_q[i] == HOLD_LAST) begin
            state_d[i] = ST_EMPTY;
            tmr_d[i]   = '0;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_ONE;
          end
        end
        default: begin
          state_d[i] = ST_EMPTY;
          tmr_d[i]   = '0;
        end
      endcase
      // Flag is registered from the next state so it changes on the transition edge.
      flag_d[i] = (state_d[i] == ST_OCC) || (state_d[i] == ST_HOLD);
    end
  end

  assign Ta = flag_q[0];
  assign Tb = flag_q[1];

`ifdef TL_SENS_CNT_EN
  logic [CNT_W-1:0] cnt_q [2];

  // Clear dominates a same-edge count event; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cnt_evt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_a = cnt_q[0];
  assign cnt_b = cnt_q[1];
`endif

endmodule

// File: tb/tb_tl_sensor_cond.sv
module tb_tl_sensor_cond;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_a;
  logic       raw_b;
  logic       clr_cnt;
  logic       Ta;
  logic       Tb;
`ifdef TL_SENS_CNT_EN
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
`endif

  int checks = 0;
  int errors = 0;
  int exp_a  = 0;
  int exp_b  = 0;

  always #5 clk = ~clk;

  tl_sensor_cond #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(8),
    .CNT_W      (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef TL_SENS_CNT_EN
    .clr_cnt(clr_cnt),
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b),
`endif
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .Ta     (Ta),
    .Tb     (Tb)
  );

  // Advance one rising edge and settle; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; raw_a = 1'b1; raw_b = 1'b1; clr_cnt = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (Ta !== 1'b0 || Tb !== 1'b0) begin
        errors++; $display("FAIL reset_flags edge %0d: got Ta=%b Tb=%b want 0 0", k, Ta, Tb);
      end
`ifdef TL_SENS_CNT_EN
      checks++;
      if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
        errors++; $display("FAIL reset_cnt edge %0d: got %0d %0d want 0 0", k, cnt_a, cnt_b);
      end
`endif
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (Ta !== (k == 6) || Tb !== (k == 6)) begin
        errors++; $display("FAIL post_reset_qual edge %0d: got Ta=%b Tb=%b want %0b", k, Ta, Tb, (k == 6));
      end
    end
    exp_a = 1; exp_b = 1;
`ifdef TL_SENS_CNT_EN
    checks++;
    if (cnt_a !== 8'(exp_a) || cnt_b !== 8'(exp_b)) begin
      errors++; $display("FAIL post_reset_cnt: got %0d %0d want %0d %0d", cnt_a, cnt_b, exp_a, exp_b);
    end
`endif
    raw_a = 1'b0; raw_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (Ta !== (k < 10) || Tb !== (k < 10)) begin
        errors++; $display("FAIL release edge %0d: got Ta=%b Tb=%b want %0b", k, Ta, Tb, (k < 10));
      end
    end
  endtask

  task automatic test_qualify();
    raw_a = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (Ta !== (k == 6)) begin
        errors++; $display("FAIL qualify_ta edge %0d: got %b want %0b", k, Ta, (k == 6));
      end
      checks++;
      if (Tb !== 1'b0) begin
        errors++; $display("FAIL qualify_tb edge %0d: got %b want 0", k, Tb);
      end
    end
    exp_a++;
`ifdef TL_SENS_CNT_EN
    checks++;
    if (cnt_a !== 8'(exp_a) || cnt_b !== 8'(exp_b)) begin
      errors++; $display("FAIL qualify_cnt: got %0d %0d want %0d %0d", cnt_a, cnt_b, exp_a, exp_b);
    end
`endif
  endtask

  task automatic test_bounce();
    raw_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (Ta !== 1'b1) begin errors++; $display("FAIL bounce_low edge %0d: got %b want 1", k, Ta); end
    end
    raw_a = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (Ta !== 1'b1) begin errors++; $display("FAIL bounce_high edge %0d: got %b want 1", k, Ta); end
    end
    raw_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (Ta !== (k < 10)) begin
        errors++; $display("FAIL bounce_release edge %0d: got %b want %0b", k, Ta, (k < 10));
      end
    end
`ifdef TL_SENS_CNT_EN
    checks++;
    if (cnt_a !== 8'(exp_a)) begin
      errors++; $display("FAIL bounce_cnt: got %0d want %0d", cnt_a, exp_a);
    end
`endif
  endtask

  task automatic test_glitch();
    raw_a = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) raw_a = 1'b0;
      step();
      checks++;
      if (Ta !== 1'b0) begin errors++; $display("FAIL glitch_ta edge %0d: got %b want 0", k, Ta); end
    end
`ifdef TL_SENS_CNT_EN
    checks++;
    if (cnt_a !== 8'(exp_a)) begin
      errors++; $display("FAIL glitch_cnt: got %0d want %0d", cnt_a, exp_a);
    end
`endif
  endtask

  task automatic test_saturate();
    for (int v = 0; v < 256; v++) begin
      raw_a = 1'b1;
      repeat (6) step();
      if (v == 0) begin
        checks++;
        if (Ta !== 1'b1) begin errors++; $display("FAIL sat_first_ta: got %b want 1", Ta); end
      end
      raw_a = 1'b0;
      repeat (10) step();
      exp_a = (exp_a < 255) ? exp_a + 1 : 255;
`ifdef TL_SENS_CNT_EN
      if (v >= 250) begin
        checks++;
        if (cnt_a !== 8'(exp_a)) begin
          errors++; $display("FAIL sat_cnt vehicle %0d: got %0d want %0d", v, cnt_a, exp_a);
        end
      end
`endif
    end
    checks++;
    if (Ta !== 1'b0) begin errors++; $display("FAIL sat_last_ta: got %b want 0", Ta); end
    // Lane B count event coincides with clear.
    raw_b = 1'b1;
    repeat (5) step();
    checks++;
    if (Tb !== 1'b0) begin errors++; $display("FAIL clr_pre_tb: got %b want 0", Tb); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_a = 0; exp_b = 0;
    checks++;
    if (Tb !== 1'b1) begin errors++; $display("FAIL clr_tb: got %b want 1", Tb); end
`ifdef TL_SENS_CNT_EN
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
      errors++; $display("FAIL clr_cnt: got %0d %0d want 0 0", cnt_a, cnt_b);
    end
`endif
  endtask

  task automatic test_midreset();
    raw_a = 1'b1;
    repeat (6) step();
    exp_a = 1;
    checks++;
    if (Ta !== 1'b1 || Tb !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got Ta=%b Tb=%b want 1 1", Ta, Tb);
    end
`ifdef TL_SENS_CNT_EN
    checks++;
    if (cnt_a !== 8'(exp_a) || cnt_b !== 8'(exp_b)) begin
      errors++; $display("FAIL midrst_pre_cnt: got %0d %0d want %0d %0d", cnt_a, cnt_b, exp_a, exp_b);
    end
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_a = 0; exp_b = 0;
    checks++;
    if (Ta !== 1'b0 || Tb !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: got Ta=%b Tb=%b want 0 0", Ta, Tb);
    end
`ifdef TL_SENS_CNT_EN
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
      errors++; $display("FAIL midrst_cnt: got %0d %0d want 0 0", cnt_a, cnt_b);
    end
`endif
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (Ta !== (k == 6) || Tb !== (k == 6)) begin
        errors++; $display("FAIL midrst_requal edge %0d: got Ta=%b Tb=%b want %0b", k, Ta, Tb, (k == 6));
      end
    end
    exp_a = 1; exp_b = 1;
`ifdef TL_SENS_CNT_EN
    checks++;
    if (cnt_a !== 8'(exp_a) || cnt_b !== 8'(exp_b)) begin
      errors++; $display("FAIL midrst_requal_cnt: got %0d %0d want %0d %0d", cnt_a, cnt_b, exp_a, exp_b);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0; clr_cnt = 1'b0;
    #2;
    test_reset();
    test_qualify();
    test_bounce();
    test_glitch();
    test_saturate();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
